uart_tx_buffered: RTL and testbench

UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

---
 rtl/uart_pkg.sv | 16 +
 rtl/sync_fifo.sv | 55 +++++
 rtl/uart_tx_buffered.sv | 137 +++++++++++++
 tb/tb_uart_tx_buffered.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: FSM encoding and 8N1 frame constants.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int   DEFAULT_CLKS_PER_BIT = 234;
  localparam int   DATA_BITS            = 8;
  localparam logic START_BIT            = 1'b0;
  localparam logic STOP_BIT             = 1'b1;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count; the head word is presented combinationally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // Full is taken from the registered count, so a pop in the same cycle never frees a slot for a push.
  assign full_o  = (count_o == (AW+1)'(DEPTH));
  assign empty_o = (count_o == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign data_o  = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem[wr_ptr] <= data_i;
    end
  end

  // Pointers are DEPTH-sized powers of two, so they wrap naturally.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_o <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_o <= count_o + 1'b1;
        2'b01:   count_o <= count_o - 1'b1;
        default: count_o <= count_o;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// 8N1 UART transmitter fed from a byte FIFO; frames are sent back-to-back while data is queued.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic [7:0]                    tx_data_i,
  input  logic                          tx_valid_i,
  output logic                          tx_ready_o,
  output logic                          uart_tx_o,
  output logic                          tx_busy_o,
  output logic                          tx_done_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

  localparam int               CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       BIT_LAST  = 3'(DATA_BITS - 1);

  tx_state_t        state_q, state_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [7:0]       fifo_data;
  logic             baud_last;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (tx_valid_i),
    .data_i  (tx_data_i),
    .pop_i   (fifo_pop),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count_o)
  );

  assign tx_ready_o = !fifo_full;
  assign uart_tx_o  = tx_q;
  assign tx_busy_o  = (state_q != IDLE);
  assign baud_last  = (baud_q == BAUD_LAST);
  assign tx_done_o  = (state_q == STOP) && baud_last;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= STOP_BIT;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  // The line value for the next cycle is computed here so that it always comes straight from tx_q.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        tx_d   = STOP_BIT;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_data;
          tx_d     = START_BIT;
          state_d  = START;
        end
      end
      START: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
          state_d = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == BIT_LAST) begin
            tx_d    = STOP_BIT;
            state_d = STOP;
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        if (baud_last) begin
          baud_d = '0;
          // Chain straight into the next start bit so queued frames have no idle gap.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_data;
            tx_d     = START_BIT;
            state_d  = START;
          end else begin
            tx_d    = STOP_BIT;
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench: a line monitor decodes frames against a queue of expected bytes.
module tb_uart_tx_buffered;

  localparam int CPB      = 4;
  localparam int SLOW_CPB = 234;
  localparam int DEPTH    = 16;
  localparam int CW       = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    tx_data = '0;
  logic          tx_valid = 1'b0;
  logic          tx_ready, uart_tx, tx_busy, tx_done;
  logic [CW-1:0] fifo_count;

  logic [7:0]    s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready, s_line, s_busy, s_done;
  logic [CW-1:0] s_count;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_q[$];
  int         busy_cnt, done_cnt, run_len, max_run, low_cnt;
  bit         mon_active = 1'b0;
  int         mon_cyc, mon_k;
  logic [7:0] mon_byte, mon_exp;

  typedef struct {
    logic [7:0] data;
    int         busy;
    int         done;
  } vec_t;
  vec_t vecs[5];

  always #5 clk = ~clk;

  uart_tx_buffered #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) u_dut (
    .clk_i(clk), .rst_n_i(rst_n), .tx_data_i(tx_data), .tx_valid_i(tx_valid),
    .tx_ready_o(tx_ready), .uart_tx_o(uart_tx), .tx_busy_o(tx_busy),
    .tx_done_o(tx_done), .fifo_count_o(fifo_count)
  );

  uart_tx_buffered #(.CLKS_PER_BIT(SLOW_CPB), .FIFO_DEPTH(DEPTH)) u_dut_slow (
    .clk_i(clk), .rst_n_i(rst_n), .tx_data_i(s_data), .tx_valid_i(s_valid),
    .tx_ready_o(s_ready), .uart_tx_o(s_line), .tx_busy_o(s_busy),
    .tx_done_o(s_done), .fifo_count_o(s_count)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] d);
    tx_valid = 1'b1;
    tx_data  = d;
    exp_q.push_back(d);
    @(posedge clk); #1;
    tx_valid = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clearStats();
    busy_cnt = 0; done_cnt = 0; max_run = 0; low_cnt = 0;
  endtask

  task automatic waitIdle(input string name, input int maxc);
    int n = 0;
    while (n < maxc && !(tx_busy == 1'b0 && fifo_count == '0 && !mon_active)) begin
      tick(1);
      n++;
    end
    checks++;
    if (n >= maxc) begin
      errors++;
      $display("[TB] FAIL %s_timeout: got busy=%0b count=%0d, expected idle within %0d cycles", name, tx_busy, fifo_count, maxc);
    end
  endtask

  // Decodes the slow instance's line by sampling mid-bit.
  task automatic rxByte(output logic [7:0] b, output bit ok);
    int n = 0;
    ok = 1'b0;
    b  = '0;
    while (s_line !== 1'b0 && n < SLOW_CPB * 30) begin
      tick(1);
      n++;
    end
    if (n >= SLOW_CPB * 30) return;
    tick(SLOW_CPB / 2);
    if (s_line !== 1'b0) return;
    for (int i = 0; i < 8; i++) begin
      tick(SLOW_CPB);
      b[i] = s_line;
    end
    tick(SLOW_CPB);
    ok = (s_line === 1'b1);
  endtask

  // Line monitor: statistics plus mid-bit frame decode checked against the expected queue.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      mon_active = 1'b0;
      run_len    = 0;
    end else begin
      if (tx_busy) begin
        busy_cnt++;
        run_len++;
        if (run_len > max_run) max_run = run_len;
      end else begin
        run_len = 0;
      end
      if (tx_done) done_cnt++;
      if (!uart_tx) low_cnt++;
      if (!mon_active) begin
        if (!uart_tx) begin
          mon_active = 1'b1;
          mon_cyc    = 0;
        end
      end else begin
        mon_cyc++;
      end
      if (mon_active && mon_cyc >= CPB / 2 && ((mon_cyc - CPB / 2) % CPB) == 0) begin
        mon_k = (mon_cyc - CPB / 2) / CPB;
        if (mon_k == 0) begin
          checkOutput("start_bit", {31'd0, uart_tx}, 32'd0);
        end else if (mon_k <= 8) begin
          mon_byte[mon_k-1] = uart_tx;
        end else begin
          checkOutput("stop_bit", {31'd0, uart_tx}, 32'd1);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_frame: got byte %0h, expected no frame", mon_byte);
          end else begin
            mon_exp = exp_q.pop_front();
            checkOutput("frame_data", {24'd0, mon_byte}, {24'd0, mon_exp});
          end
          mon_active = 1'b0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int         accepted;
    logic [7:0] rx_b;
    bit         rx_ok;

    vecs[0] = '{8'h00, 40, 1};
    vecs[1] = '{8'hFF, 40, 1};
    vecs[2] = '{8'h81, 40, 1};
    vecs[3] = '{8'h3C, 40, 1};
    vecs[4] = '{8'hA5, 40, 1};

    // Reset values
    tick(3);
    checkOutput("rst_line", {31'd0, uart_tx}, 32'd1);
    checkOutput("rst_busy", {31'd0, tx_busy}, 32'd0);
    checkOutput("rst_done", {31'd0, tx_done}, 32'd0);
    checkOutput("rst_count", {27'd0, fifo_count}, 32'd0);
    checkOutput("rst_ready", {31'd0, tx_ready}, 32'd1);
    rst_n = 1'b1;
    tick(2);

    // Single byte 0x55 with first-transaction latency
    clearStats();
    applyStimulus(8'h55);
    checkOutput("lat_line_e0", {31'd0, uart_tx}, 32'd1);
    checkOutput("lat_count_e0", {27'd0, fifo_count}, 32'd1);
    checkOutput("lat_busy_e0", {31'd0, tx_busy}, 32'd0);
    tick(1);
    checkOutput("lat_line_e1", {31'd0, uart_tx}, 32'd0);
    checkOutput("lat_count_e1", {27'd0, fifo_count}, 32'd0);
    checkOutput("lat_busy_e1", {31'd0, tx_busy}, 32'd1);
    waitIdle("single", 200);
    checkOutput("single_busy", busy_cnt, 40);
    checkOutput("single_done", done_cnt, 1);
    checkOutput("single_queue", exp_q.size(), 0);

    // Table of isolated frames
    for (int i = 0; i < 5; i++) begin
      tick(3);
      clearStats();
      applyStimulus(vecs[i].data);
      waitIdle("vec", 200);
      checkOutput($sformatf("vec%0d_busy", i), busy_cnt, vecs[i].busy);
      checkOutput($sformatf("vec%0d_done", i), done_cnt, vecs[i].done);
      checkOutput($sformatf("vec%0d_queue", i), exp_q.size(), 0);
    end

    // Back-to-back frames
    tick(3);
    clearStats();
    applyStimulus(8'hA5);
    applyStimulus(8'h00);
    applyStimulus(8'hFF);
    waitIdle("b2b", 400);
    checkOutput("b2b_busy", busy_cnt, 120);
    checkOutput("b2b_contiguous", max_run, 120);
    checkOutput("b2b_done", done_cnt, 3);
    checkOutput("b2b_queue", exp_q.size(), 0);

    // Fill to full with valid held for 20 cycles
    tick(3);
    clearStats();
    accepted = 0;
    for (int b = 0; b <= 16; b++) exp_q.push_back(8'(b));
    tx_valid = 1'b1;
    tx_data  = 8'h00;
    for (int k = 0; k < 20; k++) begin
      if (tx_ready) accepted++;
      tick(1);
      if (k == 15) begin
        checkOutput("full_count15", {27'd0, fifo_count}, 32'd15);
        checkOutput("full_ready15", {31'd0, tx_ready}, 32'd1);
      end
      if (k == 16) begin
        checkOutput("full_count16", {27'd0, fifo_count}, 32'd16);
        checkOutput("full_ready16", {31'd0, tx_ready}, 32'd0);
      end
      tx_data = 8'(k + 1);
    end
    tx_valid = 1'b0;
    checkOutput("full_accepted", accepted, 17);
    waitIdle("full", 1200);
    checkOutput("full_done", done_cnt, 17);
    checkOutput("full_queue", exp_q.size(), 0);

    // Reset during DATA bit 3 with 5 bytes queued
    tick(3);
    for (int b = 0; b < 6; b++) applyStimulus(8'h00);
    tick(14);
    checkOutput("mid_count", {27'd0, fifo_count}, 32'd5);
    checkOutput("mid_line", {31'd0, uart_tx}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_line", {31'd0, uart_tx}, 32'd1);
    checkOutput("abort_count", {27'd0, fifo_count}, 32'd0);
    checkOutput("abort_busy", {31'd0, tx_busy}, 32'd0);
    checkOutput("abort_ready", {31'd0, tx_ready}, 32'd1);
    exp_q.delete();
    tick(3);
    rst_n = 1'b1;
    tick(1);
    clearStats();
    tick(100);
    checkOutput("post_rst_low", low_cnt, 0);
    checkOutput("post_rst_busy", busy_cnt, 0);
    clearStats();
    applyStimulus(8'h5A);
    waitIdle("post_rst", 200);
    checkOutput("post_rst_done", done_cnt, 1);
    checkOutput("post_rst_queue", exp_q.size(), 0);

    // Loopback at full baud divisor
    s_valid = 1'b1;
    s_data  = 8'h3C;
    tick(1);
    s_data  = 8'hC3;
    tick(1);
    s_valid = 1'b0;
    rxByte(rx_b, rx_ok);
    checkOutput("loop0_ok", {31'd0, rx_ok}, 32'd1);
    checkOutput("loop0_byte", {24'd0, rx_b}, 32'h3C);
    rxByte(rx_b, rx_ok);
    checkOutput("loop1_ok", {31'd0, rx_ok}, 32'd1);
    checkOutput("loop1_byte", {24'd0, rx_b}, 32'hC3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
